hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage RV32I core; drives the `bubble*` (hold) and `flush*` (clear-to-zero) inputs of every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves three hazard classes: load-use data hazards, control hazards (branch/JALR resolved in EX, JAL in ID) and multi-cycle data-memory waits.
- Tracks memory waits with an FSM and timeout counter.
- Purely a sequencer; it holds no datapath state.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/hazard_detect.sv | 18 +
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int MEM_TIMEOUT_DEF = 64;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and the ID consumer.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs1_D,
    input  logic [4:0] i_rs2_D,
    input  logic       i_rs1_used_D,
    input  logic       i_rs2_used_D,
    input  logic [4:0] i_rd_E,
    input  logic       i_memread_E,
    output logic       o_loaduse
);
    logic w_rs1_hit;
    logic w_rs2_hit;
    assign w_rs1_hit = i_rs1_used_D & (i_rs1_D == i_rd_E);
    assign w_rs2_hit = i_rs2_used_D & (i_rs2_D == i_rd_E);
    assign o_loaduse = i_memread_E & (i_rd_E != REG_X0) & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline bubble/flush sequencer with memory-wait FSM and sticky timeout.
// Optional HAZARD_PERF_EN adds stall-cycle and flush-event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic       rs1_used_D,
    input  logic       rs2_used_D,
    input  logic [4:0] rd_E,
    input  logic       memread_E,
    input  logic       br_taken_E,
    input  logic       jal_D,
    input  logic       dmem_req_M,
    input  logic       dmem_ready_M,
    output logic       bubbleF,
    output logic       bubbleD,
    output logic       bubbleE,
    output logic       bubbleM,
    output logic       bubbleW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       mem_stall,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_evt
`endif
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_loaduse;
    logic             w_ms;
    logic             w_br;
    logic             w_lu;
    logic             w_jal;

    hazard_detect u_detect (
        .i_rs1_D      (rs1_D),
        .i_rs2_D      (rs2_D),
        .i_rs1_used_D (rs1_used_D),
        .i_rs2_used_D (rs2_used_D),
        .i_rd_E       (rd_E),
        .i_memread_E  (memread_E),
        .o_loaduse    (w_loaduse)
    );

    // Priority chain: memory stall > branch > load-use > jal
    assign w_ms  = dmem_req_M & ~dmem_ready_M;
    assign w_br  = ~w_ms & br_taken_E;
    assign w_lu  = ~w_ms & ~br_taken_E & w_loaduse;
    assign w_jal = ~w_ms & ~br_taken_E & ~w_loaduse & jal_D;

    assign bubbleF     = rst_n & (w_ms | w_lu);
    assign bubbleD     = rst_n & (w_ms | w_lu);
    assign bubbleE     = rst_n & w_ms;
    assign bubbleM     = rst_n & w_ms;
    assign bubbleW     = 1'b0;
    assign flushD      = ~rst_n | w_br | w_jal;
    assign flushE      = ~rst_n | w_br | w_lu;
    assign flushM      = ~rst_n;
    assign flushW      = ~rst_n | w_ms;
    assign mem_stall   = w_ms;
    assign mem_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt <= '0;
            if (w_ms) r_state <= MEM_WAIT;
        end else begin
            if (!w_ms) r_state <= RUN;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (w_ms && r_cnt == CNT_W'(MEM_TIMEOUT - 1)) r_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cyc;
    logic [31:0] r_flush_evt;
    assign perf_stall_cyc = r_stall_cyc;
    assign perf_flush_evt = r_flush_evt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cyc <= '0;
            r_flush_evt <= '0;
        end else begin
            if (bubbleF) r_stall_cyc <= r_stall_cyc + 32'd1;
            if (flushD) r_flush_evt <= r_flush_evt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_D = '0, rs2_D = '0, rd_E = '0;
    logic       rs1_used_D = 0, rs2_used_D = 0, memread_E = 0, br_taken_E = 0, jal_D = 0;
    logic       dmem_req_M = 0, dmem_ready_M = 0;
    logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic       flushD, flushE, flushM, flushW, mem_stall, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_evt;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [10:0] exp;
        logic [10:0] msk;
    } exp_t;
    exp_t sb[$];

    // bit order: bF bD bE bM bW | fD fE fM fW | mem_stall mem_timeout
    localparam logic [10:0] NONE = 11'b0;
    localparam logic [10:0] LU   = {5'b11000, 4'b0100, 2'b00};
    localparam logic [10:0] BR   = {5'b00000, 4'b1100, 2'b00};
    localparam logic [10:0] JAL  = {5'b00000, 4'b1000, 2'b00};
    localparam logic [10:0] MS   = {5'b11110, 4'b0001, 2'b10};
    localparam logic [10:0] MST  = {5'b11110, 4'b0001, 2'b11};
    localparam logic [10:0] NT   = {5'b00000, 4'b0000, 2'b01};
    localparam logic [10:0] RST  = {5'b00000, 4'b1111, 2'b00};
    localparam logic [10:0] M_MS = 11'b000_0000_0010;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
        .memread_E(memread_E), .br_taken_E(br_taken_E), .jal_D(jal_D),
        .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM),
        .bubbleW(bubbleW), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .flushW(flushW), .mem_stall(mem_stall), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_evt(perf_flush_evt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic rn, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic jl, input logic rq, input logic rdy,
                        input logic [10:0] exp, input logic [10:0] msk);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; rs1_D = r1; rs1_used_D = u1; rs2_D = r2; rs2_used_D = u2;
        rd_E = rd; memread_E = mr; br_taken_E = br; jal_D = jl;
        dmem_req_M = rq; dmem_ready_M = rdy;
        e.name = nm; e.exp = exp; e.msk = msk;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e = sb.pop_front();
            act = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                   flushD, flushE, flushM, flushW, mem_stall, mem_timeout};
            tests++;
            if (((act ^ e.exp) & ~e.msk) != 11'b0) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name         rn r1 u1 r2 u2 rd mr br jl rq rdy exp msk
        step("reset0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 11'b0);
        step("reset1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 11'b0);
        step("idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("lu_rs1",     1, 5, 1, 7, 1, 5, 1, 0, 0, 0, 0, LU, 11'b0);
        step("lu_after",   1, 5, 1, 7, 1, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("lu_x0",      1, 0, 1, 7, 1, 0, 1, 0, 0, 0, 0, NONE, 11'b0);
        step("lu_rs2",     1, 3, 1, 9, 1, 9, 1, 0, 0, 0, 0, LU, 11'b0);
        step("lu_rs2_unused", 1, 3, 1, 9, 0, 9, 1, 0, 0, 0, 0, NONE, 11'b0);
        step("lu_notload", 1, 5, 1, 7, 1, 5, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("br_over_lu", 1, 5, 1, 7, 1, 5, 1, 1, 0, 0, 0, BR, 11'b0);
        step("jal",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, JAL, 11'b0);
        step("lu_over_jal",1, 5, 1, 0, 0, 5, 1, 0, 1, 0, 0, LU, 11'b0);
        step("br_over_jal",1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, BR, 11'b0);
        step("ready_same", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 11'b0);
        step("ms1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 11'b0);
        step("ms2_br",     1, 5, 1, 0, 0, 5, 1, 1, 1, 1, 0, MS, 11'b0);
        step("ms3",        1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 11'b0);
        step("ms_ready",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 11'b0);
        step("ms_done",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        for (int i = 1; i <= 10; i++)
            step($sformatf("to_%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i <= 5) ? MS : MST, 11'b0);
        step("to_ready",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NT, 11'b0);
        step("to_sticky",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NT, 11'b0);
        step("rw_ms1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 11'b0);
        step("rw_ms2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MST, 11'b0);
        step("rst_midwait",0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, M_MS);
        step("rst_rel",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("rst_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("new_req",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MS, 11'b0);
        step("new_ready",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 11'b0);
`ifdef HAZARD_PERF_EN
        step("p_rst",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 11'b0);
        step("p_lu1",      1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, LU, 11'b0);
        step("p_n1",       1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("p_lu2",      1, 0, 0, 6, 1, 6, 1, 0, 0, 0, 0, LU, 11'b0);
        step("p_n2",       1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        step("p_br",       1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, BR, 11'b0);
        step("p_n3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 11'b0);
        @(negedge clk);
        #1;
        tests++;
        if (perf_stall_cyc != 32'd2) begin
            fails++;
            $display("FAIL perf_stall_cyc: got %0d expected 2", perf_stall_cyc);
        end
        tests++;
        if (perf_flush_evt != 32'd1) begin
            fails++;
            $display("FAIL perf_flush_evt: got %0d expected 1", perf_flush_evt);
        end
`endif
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
